// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Common-data-bus arbiter. Two per-source result FIFOs (ALU, LSB)
//            feed one registered broadcast per cycle, with round-robin
//            arbitration under contention. The whole block freezes while
//            rdy_in is low. predict_fail flushes both queues and the bus.
// Ports    : clk_in, rst_in (sync, active-high), rdy_in (global ready)
//            alu_valid/tag/val/addr -> alu_ready  : ALU result offer
//            lsb_valid/tag/val/addr -> lsb_ready  : LSB result offer
//            predict_fail                         : misprediction flush
//            cdb_active/tag/val/addr              : registered broadcast
//            stat_bcast_cnt/stat_stall_cnt        : statistics counters
// Options  : CDB_STATS_EN - when defined, the statistics counters are built.
//            When undefined, both stat outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        alu_valid,
    input  logic [3:0]  alu_tag,
    input  logic [31:0] alu_val,
    input  logic [31:0] alu_addr,
    output logic        alu_ready,
    input  logic        lsb_valid,
    input  logic [3:0]  lsb_tag,
    input  logic [31:0] lsb_val,
    input  logic [31:0] lsb_addr,
    output logic        lsb_ready,
    input  logic        predict_fail,
    output logic        cdb_active,
    output logic [3:0]  cdb_tag,
    output logic [31:0] cdb_val,
    output logic [31:0] cdb_addr,
    output logic [31:0] stat_bcast_cnt,
    output logic [31:0] stat_stall_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 68;                       // {tag, val, addr}
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Normal-advance and flush qualifiers; reset beats pause beats flush.
    logic adv_w;
    logic flush_w;
    assign adv_w   = !rst_in && rdy_in && !predict_fail;
    assign flush_w = !rst_in && rdy_in && predict_fail;

    // Per-source views: index 0 = ALU, 1 = LSB.
    logic          valid_w [2];
    logic [EW-1:0] din_w   [2];
    logic          ready_w [2];
    logic          nempty_w[2];
    logic          push_w  [2];
    logic          pop_w   [2];
    logic [EW-1:0] head_w  [2];

    assign valid_w[0] = alu_valid;
    assign valid_w[1] = lsb_valid;
    assign din_w[0]   = {alu_tag, alu_val, alu_addr};
    assign din_w[1]   = {lsb_tag, lsb_val, lsb_addr};
    assign alu_ready  = ready_w[0];
    assign lsb_ready  = ready_w[1];

    // Arbitration uses registered occupancy only, so a result pushed at one
    // edge is never popped before the following edge.
    logic rr_q, rr_d;
    logic grant_alu_w, grant_lsb_w, contend_w;
    assign contend_w   = nempty_w[0] && nempty_w[1];
    assign grant_alu_w = nempty_w[0] && (!nempty_w[1] || !rr_q);
    assign grant_lsb_w = nempty_w[1] && !grant_alu_w;
    assign pop_w[0]    = adv_w && grant_alu_w;
    assign pop_w[1]    = adv_w && grant_lsb_w;

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic [EW-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr_q, wr_ptr_d;
        logic [AW-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] cnt_q, cnt_d;

        assign ready_w[s]  = (cnt_q != FULL_CNT);
        assign nempty_w[s] = (cnt_q != '0);
        // Tag 0 means "no destination": accepted by the handshake, then dropped.
        assign push_w[s]   = adv_w && valid_w[s] && ready_w[s] &&
                             (din_w[s][EW-1 -: 4] != 4'b0);
        assign head_w[s]   = mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = push_w[s] ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop_w[s]  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            cnt_d    = cnt_q + {{(CW-1){1'b0}}, push_w[s]}
                             - {{(CW-1){1'b0}}, pop_w[s]};
        end

        always_ff @(posedge clk_in) begin
            if (rst_in || flush_w) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage needs no reset: occupancy gates every read.
        always_ff @(posedge clk_in) begin
            if (push_w[s]) begin
                mem_q[wr_ptr_q] <= din_w[s];
            end
        end
    end

    // Broadcast register.
    logic        act_q,  act_d;
    logic [3:0]  tag_q,  tag_d;
    logic [31:0] val_q,  val_d;
    logic [31:0] addr_q, addr_d;

    always_comb begin
        act_d  = act_q;
        tag_d  = tag_q;
        val_d  = val_q;
        addr_d = addr_q;
        rr_d   = rr_q;
        if (flush_w) begin
            act_d = 1'b0;
            tag_d = 4'b0;
            rr_d  = 1'b0;
        end else if (adv_w) begin
            if (grant_alu_w || grant_lsb_w) begin
                act_d = 1'b1;
                {tag_d, val_d, addr_d} = grant_alu_w ? head_w[0] : head_w[1];
                if (contend_w) begin
                    rr_d = ~rr_q;
                end
            end else begin
                // val/addr deliberately hold their last broadcast value.
                act_d = 1'b0;
                tag_d = 4'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            act_q  <= 1'b0;
            tag_q  <= 4'b0;
            val_q  <= 32'b0;
            addr_q <= 32'b0;
            rr_q   <= 1'b0;
        end else begin
            act_q  <= act_d;
            tag_q  <= tag_d;
            val_q  <= val_d;
            addr_q <= addr_d;
            rr_q   <= rr_d;
        end
    end

    assign cdb_active = act_q;
    assign cdb_tag    = tag_q;
    assign cdb_val    = val_q;
    assign cdb_addr   = addr_q;

`ifdef CDB_STATS_EN
    logic [31:0] bcast_q, bcast_d;
    logic [31:0] stall_q, stall_d;
    logic        stall_w;

    // A stall is any offered result refused for lack of space while running;
    // flush cycles still count because they are not paused.
    assign stall_w = rdy_in && ((alu_valid && !ready_w[0]) ||
                                (lsb_valid && !ready_w[1]));

    always_comb begin
        bcast_d = bcast_q + ((adv_w && (grant_alu_w || grant_lsb_w)) ? 32'd1 : 32'd0);
        stall_d = stall_q + (stall_w ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bcast_q <= 32'b0;
            stall_q <= 32'b0;
        end else begin
            bcast_q <= bcast_d;
            stall_q <= stall_d;
        end
    end

    assign stat_bcast_cnt = bcast_q;
    assign stat_stall_cnt = stall_q;
`else
    assign stat_bcast_cnt = 32'b0;
    assign stat_stall_cnt = 32'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter. A queue-based model of the
//            two result queues and the broadcast register is compared with
//            the DUT every cycle; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int D = 2;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, predict_fail;
    logic        alu_valid, lsb_valid;
    logic [3:0]  alu_tag, lsb_tag;
    logic [31:0] alu_val, alu_addr, lsb_val, lsb_addr;
    logic        alu_ready, lsb_ready;
    logic        cdb_active;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val, cdb_addr;
    logic [31:0] stat_bcast_cnt, stat_stall_cnt;

    cdb_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_val(alu_val),
        .alu_addr(alu_addr), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val),
        .lsb_addr(lsb_addr), .lsb_ready(lsb_ready),
        .predict_fail(predict_fail),
        .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .cdb_addr(cdb_addr),
        .stat_bcast_cnt(stat_bcast_cnt), .stat_stall_cnt(stat_stall_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_pass = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    logic [67:0] aq[$];
    logic [67:0] lq[$];
    bit          m_rr;
    bit          m_act;
    logic [3:0]  m_tag;
    logic [31:0] m_val, m_addr, m_bc, m_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Applies one rising edge's worth of rules to the model, using the
    // inputs currently driven.
    task automatic model_step();
        int na, nl;
        bit ga, gl;
        logic [67:0] e;
        na = aq.size();
        nl = lq.size();
        if (rst_in) begin
            aq.delete(); lq.delete();
            m_rr = 0; m_act = 0; m_tag = 0; m_val = 0; m_addr = 0;
            m_bc = 0; m_st = 0;
        end else if (rdy_in) begin
            if ((alu_valid && na == D) || (lsb_valid && nl == D)) m_st++;
            if (predict_fail) begin
                aq.delete(); lq.delete();
                m_act = 0; m_tag = 0; m_rr = 0;
            end else begin
                ga = (na > 0) && (nl == 0 || !m_rr);
                gl = (nl > 0) && !ga;
                if (na > 0 && nl > 0) m_rr = !m_rr;
                e = '0;
                if (ga) e = aq.pop_front();
                else if (gl) e = lq.pop_front();
                if (ga || gl) begin
                    m_act = 1;
                    {m_tag, m_val, m_addr} = e;
                    m_bc++;
                end else begin
                    m_act = 0;
                    m_tag = 0;
                end
                if (alu_valid && na < D && alu_tag != 0) aq.push_back({alu_tag, alu_val, alu_addr});
                if (lsb_valid && nl < D && lsb_tag != 0) lq.push_back({lsb_tag, lsb_val, lsb_addr});
            end
        end
    endtask

    task automatic compare();
        logic [31:0] ebc, est;
`ifdef CDB_STATS_EN
        ebc = m_bc;
        est = m_st;
`else
        ebc = 0;
        est = 0;
`endif
        chk("alu_ready", {31'b0, alu_ready}, {31'b0, aq.size() != D});
        chk("lsb_ready", {31'b0, lsb_ready}, {31'b0, lq.size() != D});
        chk("cdb_active", {31'b0, cdb_active}, {31'b0, m_act});
        chk("cdb_tag", {28'b0, cdb_tag}, {28'b0, m_tag});
        chk("cdb_val", cdb_val, m_val);
        chk("cdb_addr", cdb_addr, m_addr);
        chk("stat_bcast", stat_bcast_cnt, ebc);
        chk("stat_stall", stat_stall_cnt, est);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk_in);
        compare();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_in();
        rst_in = 0; rdy_in = 1; predict_fail = 0;
        alu_valid = 0; alu_tag = 0; alu_val = 0; alu_addr = 0;
        lsb_valid = 0; lsb_tag = 0; lsb_val = 0; lsb_addr = 0;
    endtask

    task automatic offer_a(input logic [3:0] t, input logic [31:0] v, input logic [31:0] a);
        alu_valid = 1; alu_tag = t; alu_val = v; alu_addr = a;
    endtask

    task automatic offer_l(input logic [3:0] t, input logic [31:0] v, input logic [31:0] a);
        lsb_valid = 1; lsb_tag = t; lsb_val = v; lsb_addr = a;
    endtask

    task automatic do_reset();
        idle_in();
        rst_in = 1;
        tick();
        rst_in = 0;
    endtask

    initial begin
        idle_in();
        do_reset();
        chk("rst_active", {31'b0, cdb_active}, 32'd0);
        chk("rst_ready", {30'b0, alu_ready, lsb_ready}, 32'd3);
        chk("rst_val", cdb_val, 32'd0);

        // Single ALU result, two-edge latency, then idle.
        offer_a(4'd3, 32'h1234, 32'h80); tick();
        chk("lat_pre_active", {31'b0, cdb_active}, 32'd0);
        idle_in(); tick();
        chk("single_active", {31'b0, cdb_active}, 32'd1);
        chk("single_tag", {28'b0, cdb_tag}, 32'd3);
        chk("single_val", cdb_val, 32'h1234);
        chk("single_addr", cdb_addr, 32'h80);
        tick();
        chk("single_done_active", {31'b0, cdb_active}, 32'd0);
        chk("single_done_tag", {28'b0, cdb_tag}, 32'd0);
        chk("single_hold_val", cdb_val, 32'h1234);

        // Round-robin under contention.
        do_reset();
        offer_a(4'd1, 32'h11, 32'h10); offer_l(4'd2, 32'h22, 32'h20); tick();
        idle_in(); tick(); chk("rr1_first", {28'b0, cdb_tag}, 32'd1);
        tick();            chk("rr1_second", {28'b0, cdb_tag}, 32'd2);
        offer_a(4'd1, 32'h11, 32'h10); offer_l(4'd2, 32'h22, 32'h20); tick();
        idle_in(); tick(); chk("rr2_first", {28'b0, cdb_tag}, 32'd2);
        tick();            chk("rr2_second", {28'b0, cdb_tag}, 32'd1);

        // ALU queue fills while LSB holds priority; tag 3 waits for space.
        do_reset();
        offer_a(4'd7, 32'h7, 32'h7); offer_l(4'd8, 32'h8, 32'h8); tick();
        idle_in(); offer_l(4'd9, 32'h9, 32'h9); tick();
        chk("full_b7", {28'b0, cdb_tag}, 32'd7);
        idle_in(); offer_a(4'd1, 32'h1, 32'h1); tick();
        chk("full_b8", {28'b0, cdb_tag}, 32'd8);
        offer_a(4'd2, 32'h2, 32'h2); tick();
        chk("full_b9", {28'b0, cdb_tag}, 32'd9);
        chk("full_alu_ready", {31'b0, alu_ready}, 32'd0);
        offer_a(4'd3, 32'h3, 32'h3); tick();
        chk("full_b1", {28'b0, cdb_tag}, 32'd1);
        tick();
        chk("full_b2", {28'b0, cdb_tag}, 32'd2);
        idle_in(); tick();
        chk("full_b3", {28'b0, cdb_tag}, 32'd3);
        tick();
        chk("full_drained", {31'b0, cdb_active}, 32'd0);

        // Flush with two results queued.
        offer_a(4'd6, 32'h6, 32'h6); offer_l(4'd7, 32'h7, 32'h7); tick();
        idle_in(); predict_fail = 1; tick();
        chk("flush_active", {31'b0, cdb_active}, 32'd0);
        chk("flush_ready", {30'b0, alu_ready, lsb_ready}, 32'd3);
        predict_fail = 0; tick();
        chk("flush_quiet", {31'b0, cdb_active}, 32'd0);
        offer_a(4'd5, 32'h55, 32'h50); tick();
        idle_in(); tick();
        chk("flush_next_tag", {28'b0, cdb_tag}, 32'd5);

        // Pause while a broadcast is pending.
        offer_a(4'd4, 32'h44, 32'h40); tick();
        idle_in(); offer_l(4'd11, 32'hbb, 32'hb0); tick();
        chk("pause_pre_tag", {28'b0, cdb_tag}, 32'd4);
        for (int i = 0; i < 3; i++) begin
            idle_in(); rdy_in = 0; offer_a(4'd9, 32'h99, 32'h90);
            tick();
            chk("pause_hold_tag", {28'b0, cdb_tag}, 32'd4);
            chk("pause_hold_active", {31'b0, cdb_active}, 32'd1);
        end
        idle_in(); tick();
        chk("pause_resume_tag", {28'b0, cdb_tag}, 32'd11);
        tick();
        chk("pause_empty", {31'b0, cdb_active}, 32'd0);

        // Tag 0 is swallowed; broadcast counter after three broadcasts.
        offer_a(4'd0, 32'hdead, 32'hbeef); tick();
        idle_in(); tick();
        chk("tag0_none", {31'b0, cdb_active}, 32'd0);
        do_reset();
        offer_a(4'd1, 32'h1, 32'h1); tick();
        offer_a(4'd2, 32'h2, 32'h2); tick();
        offer_a(4'd3, 32'h3, 32'h3); tick();
        idle_in(); tick(); tick();
`ifdef CDB_STATS_EN
        chk("stat_bcast_3", stat_bcast_cnt, 32'd3);
`else
        chk("stat_bcast_off", stat_bcast_cnt, 32'd0);
`endif

        // Randomised traffic.
        for (int c = 0; c < 4000; c++) begin
            rst_in       = ($urandom_range(0, 299) == 0);
            rdy_in       = ($urandom_range(0, 7) != 0);
            predict_fail = ($urandom_range(0, 49) == 0);
            alu_valid    = ($urandom_range(0, 3) != 0);
            lsb_valid    = ($urandom_range(0, 3) != 0);
            alu_tag  = 4'($urandom_range(0, 15));
            lsb_tag  = 4'($urandom_range(0, 15));
            alu_val  = $urandom; alu_addr = $urandom;
            lsb_val  = $urandom; lsb_addr = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
